// File: rtl/ex_stage_pkg.sv
// Types produced by the EX stage and consumed by the memory stage.
package ex_stage_pkg;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] opr_b;
    logic [31:0] opr_res;
    logic        rf_en;
    logic        dm_en;
    logic [1:0]  wb_sel;
    logic        br_taken;
  } ex_stage_out_t;

endpackage

// File: rtl/mem_stage_pkg.sv
// Memory-stage types: output record, FSM states and small classification helpers.
package mem_stage_pkg;
  import ex_stage_pkg::ex_stage_out_t;

  localparam logic [1:0] WB_SEL_MEM = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] opr_res;
    logic [31:0] ld_data;
    logic        rf_en;
    logic [1:0]  wb_sel;
    logic        err;
  } mem_stage_out_t;

  // A store is dm_en; a load is a non-store that writes back from memory.
  function automatic logic is_mem_op(input ex_stage_out_t ex);
    return ex.dm_en || (ex.wb_sel == WB_SEL_MEM);
  endfunction

  // An errored result never writes the register file and carries no load data.
  function automatic mem_stage_out_t make_out(input logic [4:0]  rd,
                                              input logic [31:0] opr_res,
                                              input logic [31:0] ld_data,
                                              input logic        rf_en,
                                              input logic [1:0]  wb_sel,
                                              input logic        err);
    mem_stage_out_t o;
    o.rd      = rd;
    o.opr_res = opr_res;
    o.ld_data = err ? 32'h0 : ld_data;
    o.rf_en   = rf_en & ~err;
    o.wb_sel  = wb_sel;
    o.err     = err;
    return o;
  endfunction

endpackage

// File: rtl/mem_stage.sv
// Pipeline memory stage: pass-through, aligned load/store over a req/gnt/rvalid bus,
// misaligned and timeout errors reported through err and a one-cycle bus_err pulse.
module mem_stage
  import ex_stage_pkg::*;
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst_n,
  input  ex_stage_out_t  ex_in,
  input  logic           ex_valid,
  output logic           ex_ready,
  output mem_stage_out_t mem_out,
  output logic           mem_valid,
  input  logic           wb_ready,
  output logic           dm_req,
  output logic           dm_we,
  output logic [31:0]    dm_addr,
  output logic [31:0]    dm_wdata,
  input  logic           dm_gnt,
  input  logic           dm_rvalid,
  input  logic [31:0]    dm_rdata,
  output logic           bus_err,
  output mem_state_e     dbg_state
);

  localparam int CW = $clog2(TIMEOUT + 1);

  mem_state_e     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  mem_stage_out_t mem_out_q, mem_out_d;
  logic           mem_valid_q, mem_valid_d;
  logic           dm_req_q, dm_req_d;
  logic           dm_we_q, dm_we_d;
  logic [31:0]    dm_addr_q, dm_addr_d;
  logic [31:0]    dm_wdata_q, dm_wdata_d;
  logic [4:0]     hold_rd_q, hold_rd_d;
  logic           hold_rf_en_q, hold_rf_en_d;
  logic [1:0]     hold_wb_sel_q, hold_wb_sel_d;
  logic           xfer, misaligned, timed_out, fail, bus_err_c;
  logic           unused_br_taken;

  // Handshakes: a beat moves on a rising edge where valid && ready; ready never
  // depends on valid, and the sender holds its payload until the beat moves.
  assign ex_ready   = (state_q == IDLE) && (!mem_valid_q || wb_ready);
  assign xfer       = ex_valid && ex_ready;
  assign misaligned = ex_in.opr_res[1:0] != 2'b00;
  assign timed_out  = cnt_q == CW'(TIMEOUT - 1);
  assign unused_br_taken = ex_in.br_taken;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mem_out_d     = mem_out_q;
    mem_valid_d   = mem_valid_q && !wb_ready;
    dm_req_d      = dm_req_q;
    dm_we_d       = dm_we_q;
    dm_addr_d     = dm_addr_q;
    dm_wdata_d    = dm_wdata_q;
    hold_rd_d     = hold_rd_q;
    hold_rf_en_d  = hold_rf_en_q;
    hold_wb_sel_d = hold_wb_sel_q;
    fail          = 1'b0;
    bus_err_c     = 1'b0;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (!is_mem_op(ex_in) || misaligned) begin
            mem_out_d   = make_out(ex_in.rd, ex_in.opr_res, 32'h0, ex_in.rf_en,
                                   ex_in.wb_sel, is_mem_op(ex_in));
            mem_valid_d = 1'b1;
            bus_err_c   = is_mem_op(ex_in);
          end else begin
            state_d       = REQ;
            cnt_d         = '0;
            dm_req_d      = 1'b1;
            dm_we_d       = ex_in.dm_en;
            dm_addr_d     = ex_in.opr_res;
            dm_wdata_d    = ex_in.opr_b;
            hold_rd_d     = ex_in.rd;
            hold_rf_en_d  = ex_in.rf_en;
            hold_wb_sel_d = ex_in.wb_sel;
          end
        end
      end
      REQ: begin
        if (dm_gnt) begin
          dm_req_d = 1'b0;
          if (dm_we_q) begin
            mem_out_d   = make_out(hold_rd_q, dm_addr_q, 32'h0, hold_rf_en_q,
                                   hold_wb_sel_q, 1'b0);
            mem_valid_d = 1'b1;
            state_d     = IDLE;
          end else begin
            // A same-cycle rvalid is deliberately not looked at here.
            state_d = RSP;
            cnt_d   = '0;
          end
        end else if (timed_out) begin
          fail = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RSP: begin
        if (dm_rvalid) begin
          mem_out_d   = make_out(hold_rd_q, dm_addr_q, dm_rdata, hold_rf_en_q,
                                 hold_wb_sel_q, 1'b0);
          mem_valid_d = 1'b1;
          state_d     = IDLE;
        end else if (timed_out) begin
          fail = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (fail) begin
      mem_out_d   = make_out(hold_rd_q, dm_addr_q, 32'h0, hold_rf_en_q,
                             hold_wb_sel_q, 1'b1);
      mem_valid_d = 1'b1;
      dm_req_d    = 1'b0;
      bus_err_c   = 1'b1;
      state_d     = IDLE;
      cnt_d       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      mem_out_q     <= '0;
      mem_valid_q   <= 1'b0;
      dm_req_q      <= 1'b0;
      dm_we_q       <= 1'b0;
      dm_addr_q     <= '0;
      dm_wdata_q    <= '0;
      hold_rd_q     <= '0;
      hold_rf_en_q  <= 1'b0;
      hold_wb_sel_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mem_out_q     <= mem_out_d;
      mem_valid_q   <= mem_valid_d;
      dm_req_q      <= dm_req_d;
      dm_we_q       <= dm_we_d;
      dm_addr_q     <= dm_addr_d;
      dm_wdata_q    <= dm_wdata_d;
      hold_rd_q     <= hold_rd_d;
      hold_rf_en_q  <= hold_rf_en_d;
      hold_wb_sel_q <= hold_wb_sel_d;
    end
  end

  // The error pulse marks the deciding cycle itself, so it is not registered.
  assign bus_err   = rst_n && bus_err_c;
  assign mem_out   = mem_out_q;
  assign mem_valid = mem_valid_q;
  assign dm_req    = dm_req_q;
  assign dm_we     = dm_we_q;
  assign dm_addr   = dm_addr_q;
  assign dm_wdata  = dm_wdata_q;
  assign dbg_state = state_q;

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT, default 255: the maximum number of cycles spent waiting for dm_gnt or dm_rvalid before a bus error is declared.
REQ-002 clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  synchronous, active-low reset.
REQ-004 ex_in  in  ex_stage_out_t  EX stage result: rd, opr_b (store data), opr_res (result/address), rf_en, dm_en, wb_sel, br_taken.
REQ-005 ex_valid  in  1  ex_in holds a valid instruction.
REQ-006 ex_ready  out  1  mem_stage accepts ex_in this cycle.
REQ-007 mem_out  out  mem_stage_out_t  result registered for the WB stage.
REQ-008 mem_valid  out  1  mem_out is valid.
REQ-009 wb_ready  in  1  WB consumes mem_out this cycle.
REQ-010 dm_req  out  1  data-memory request.
REQ-011 dm_we  out  1  1 = store, 0 = load.
REQ-012 dm_addr  out  32  word address, equal to the captured opr_res.
REQ-013 dm_wdata  out  32  store data, equal to the captured opr_b.
REQ-014 dm_gnt  in  1  request accepted.
REQ-015 dm_rvalid  in  1  load data valid.
REQ-016 dm_rdata  in  32  load data.
REQ-017 bus_err  out  1  one-cycle pulse on a misaligned access or a timeout.

Function
REQ-018 Classification rules: a store is dm_en=1; a load is dm_en=0 with wb_sel=WB_SEL_MEM (2'd2); any other instruction is a pass-through.
REQ-019 The FSM SHALL have three states: IDLE, REQ and RSP.
REQ-020 ex_ready SHALL be 1 only when state=IDLE and (mem_valid=0 or wb_ready=1).
REQ-021 Handshake: a transfer occurs on ex_valid & ex_ready; ex_in is sampled only on a transfer.
REQ-022 Pass-through: on a transfer, mem_out SHALL be loaded on the same edge (ld_data=0, err=0) and mem_valid=1 the next cycle; latency is 1 cycle.
REQ-023 Aligned memory op (opr_res[1:0]=0): ex_in SHALL be captured into an internal holding register, with transition IDLE->REQ; mem_out is not written on this edge.
REQ-024 While in REQ, dm_req=1, and dm_we, dm_addr and dm_wdata SHALL be held stable until dm_gnt.
REQ-025 On a store with dm_gnt in REQ: mem_out is loaded, mem_valid=1 the next cycle, and REQ->IDLE.
REQ-026 On a load with dm_gnt in REQ: REQ->RSP; dm_req=0 while in RSP.
REQ-027 On dm_rvalid in RSP: mem_out.ld_data=dm_rdata, mem_valid=1 the next cycle, and RSP->IDLE.
REQ-028 Same-cycle dm_gnt and dm_rvalid in REQ SHALL be ignored for the rvalid part; the response is accepted only in RSP.
REQ-029 The output register is guaranteed empty at memory completion, by REQ-020 and by the absence of any acceptance in REQ/RSP; completion never stalls.
REQ-030 mem_valid SHALL clear on wb_ready unless the register is reloaded on the same edge.
REQ-031 Misaligned memory op: no dm_req; mem_out loaded as for a pass-through with err=1 and rf_en=0; bus_err pulses on the acceptance cycle.
REQ-032 Timeout counter: cleared on entry to REQ and to RSP, incremented each cycle spent there; on reaching TIMEOUT it SHALL complete the op with err=1, rf_en=0 and ld_data=0, pulse bus_err, and return to IDLE.
REQ-033 dm_rvalid or dm_gnt outside REQ/RSP SHALL be ignored.
REQ-034 mem_out.rd, opr_res, rf_en and wb_sel SHALL propagate unchanged from ex_in, except for the err cases.

Reset
REQ-035 When rst_n=0 at a clock edge: state=IDLE, mem_valid=0, mem_out=0, dm_req=0, dm_we=0, dm_addr=0, dm_wdata=0, bus_err=0, counter=0.
REQ-036 Reset asserted mid-operation SHALL abandon the access; a late dm_rvalid is ignored per REQ-033.

Structure
REQ-037 Package mem_stage_pkg SHALL import ex_stage_pkg::ex_stage_out_t and define mem_stage_out_t {rd[4:0], opr_res[31:0], ld_data[31:0], rf_en, wb_sel[1:0], err}, the state enum, and WB_SEL_MEM.
REQ-038 The block SHALL be a single module with no sub-modules.

Verification
REQ-039 Pass-through: opr_res=0x1234, rd=5, with wb_ready=1 -> mem_valid is high one cycle later, mem_out.opr_res=0x1234, and dm_req is never raised.
REQ-040 Load: addr 0x100, dm_gnt after 2 cycles, dm_rvalid 3 cycles later with 0xDEADBEEF -> ld_data=0xDEADBEEF, and ex_ready stays low throughout.
REQ-041 Store: dm_en=1, opr_b=0xCAFE0001, addr 0x200, dm_gnt held low 4 cycles -> dm_req, dm_addr and dm_wdata are stable all 4 cycles, then mem_valid.
REQ-042 Misaligned: a load at 0x102 -> no dm_req, bus_err pulses once, err=1, rf_en=0.
REQ-043 Timeout: TIMEOUT=8 and dm_gnt never asserted -> bus_err in cycle 8 of REQ, err=1, ld_data=0; the next op proceeds normally.
REQ-044 Backpressure/reset: wb_ready=0 with mem_valid=1 -> ex_ready=0 and mem_out held; rst_n=0 while in RSP -> IDLE and mem_valid=0 the next cycle, and a late dm_rvalid is ignored.
